// File: rtl/controlador_frota.sv
// -----------------------------------------------------------------------------
// controlador_frota
// Fleet controller for the enemy formation: generates the march tick
// (passo / descer), keeps the per-enemy live mask, arbitrates bullet hits
// (one kill per bullet, lowest index wins) and tracks the wave state
// (OCIOSO, MARCHA, LIMPA, INVADIDO).
//
// Ports
//   CLOCK_50      system clock
//   resetInimigo  asynchronous, active-high reset
//   pausa         freezes the tick counter and march pulses (hits still work)
//   iniciar       one-cycle pulse: start / restart a wave
//   borda         some live enemy touches a horizontal screen limit
//   fundo         some live enemy reached the player row
//   hit_req[N]    per-enemy bullet overlap requests
//   passo         one-cycle pulse: move 2 px in direction sentido
//   sentido       march direction (1 = right, 0 = left)
//   descer        one-cycle pulse: move down 20 px
//   vivo[N]       live mask
//   n_vivos       number of live enemies
//   acerto        one-cycle pulse: hit granted, bullet consumed
//   id_acerto     index of the last granted hit
//   onda_fim      high while the wave is cleared (LIMPA)
//   invadido      high while the fleet has invaded (INVADIDO)
//
// Build option
//   ACELERA_EN    when defined, the tick period shrinks by DEC for every
//                 destroyed enemy, floored at DIV_MIN, sampled at each wrap.
//                 When undefined the period is fixed at DIV.
// -----------------------------------------------------------------------------
module controlador_frota #(
    parameter int N       = 8,
    parameter int DIV     = 320000,
    parameter int DIV_MIN = 80000,
    parameter int DEC     = 30000,
    localparam int NW     = $clog2(N + 1),
    localparam int IW     = (N > 1) ? $clog2(N) : 1,
    localparam int CW     = $clog2(DIV + 1)
) (
    input  logic          CLOCK_50,
    input  logic          resetInimigo,
    input  logic          pausa,
    input  logic          iniciar,
    input  logic          borda,
    input  logic          fundo,
    input  logic [N-1:0]  hit_req,
    output logic          passo,
    output logic          sentido,
    output logic          descer,
    output logic [N-1:0]  vivo,
    output logic [NW-1:0] n_vivos,
    output logic          acerto,
    output logic [IW-1:0] id_acerto,
    output logic          onda_fim,
    output logic          invadido
);

    typedef enum logic [1:0] {
        OCIOSO   = 2'd0,
        MARCHA   = 2'd1,
        LIMPA    = 2'd2,
        INVADIDO = 2'd3
    } estado_t;

    estado_t        estado_r, estado_nx_s;
    logic [CW-1:0]  cnt_r;
    logic [CW-1:0]  periodo_s;
    logic [N-1:0]   vivo_r;
    logic [NW-1:0]  n_vivos_r;
    logic [IW-1:0]  id_acerto_r;
    logic           sentido_r, passo_r, descer_r, acerto_r;
    logic           bloqueio_r, desceu_r;
    logic           onda_fim_r, invadido_r;
    logic           onda_fim_s, invadido_s;
    logic           marcha_s, tick_s, desce_s, grant_s;
    logic [N-1:0]   cand_s;
    logic [IW-1:0]  idx_s;

    // Lowest set index of a request mask (the caller guarantees it is nonzero).
    function automatic logic [IW-1:0] menor_f(input logic [N-1:0] m);
        logic [IW-1:0] idx;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = IW'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

`ifdef ACELERA_EN
    logic [CW-1:0] periodo_r;

    // Accelerated period for a given live count, floored at DIV_MIN.
    function automatic logic [CW-1:0] periodo_f(input logic [NW-1:0] n);
        int red;
        red = (N - int'(n)) * DEC;
        if (DIV - red < DIV_MIN) begin
            return CW'(DIV_MIN);
        end else begin
            return CW'(DIV - red);
        end
    endfunction

    // Period register: reloaded on wave start, resampled at every wrap.
    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            periodo_r <= CW'(DIV);
        end else if (iniciar) begin
            periodo_r <= CW'(DIV);
        end else if (tick_s) begin
            periodo_r <= periodo_f(n_vivos_r);
        end else begin
            periodo_r <= periodo_r;
        end
    end

    assign periodo_s = periodo_r;
`else
    assign periodo_s = CW'(DIV);
`endif

    // Tick and hit qualification; iniciar takes priority and suppresses both.
    always_comb begin
        marcha_s = (estado_r == MARCHA) && !iniciar;
        tick_s   = marcha_s && !pausa && (cnt_r == periodo_s - CW'(1));
        desce_s  = borda && !desceu_r;
        cand_s   = hit_req & vivo_r;
        grant_s  = marcha_s && !bloqueio_r && (cand_s != '0);
        idx_s    = menor_f(cand_s);
    end

    // FSM state register.
    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            estado_r <= OCIOSO;
        end else begin
            estado_r <= estado_nx_s;
        end
    end

    // FSM next state: fundo outranks a cleared wave, iniciar outranks all.
    always_comb begin
        estado_nx_s = estado_r;
        if (iniciar) begin
            estado_nx_s = MARCHA;
        end else begin
            case (estado_r)
                MARCHA: begin
                    if (fundo) begin
                        estado_nx_s = INVADIDO;
                    end else if (n_vivos_r == '0) begin
                        estado_nx_s = LIMPA;
                    end else begin
                        estado_nx_s = MARCHA;
                    end
                end
                default: estado_nx_s = estado_r;
            endcase
        end
    end

    // FSM outputs, decoded from the next state so they register with it.
    always_comb begin
        onda_fim_s = 1'b0;
        invadido_s = 1'b0;
        case (estado_nx_s)
            LIMPA:    onda_fim_s = 1'b1;
            INVADIDO: invadido_s = 1'b1;
            default: begin
                onda_fim_s = 1'b0;
                invadido_s = 1'b0;
            end
        endcase
    end

    // Status flag registers.
    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            onda_fim_r <= 1'b0;
            invadido_r <= 1'b0;
        end else begin
            onda_fim_r <= onda_fim_s;
            invadido_r <= invadido_s;
        end
    end

    // March datapath: tick counter, direction, one-drop-per-edge memory.
    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            cnt_r     <= '0;
            sentido_r <= 1'b0;
            desceu_r  <= 1'b0;
            passo_r   <= 1'b0;
            descer_r  <= 1'b0;
        end else if (iniciar) begin
            cnt_r     <= '0;
            sentido_r <= 1'b0;
            desceu_r  <= 1'b0;
            passo_r   <= 1'b0;
            descer_r  <= 1'b0;
        end else begin
            passo_r  <= tick_s && !desce_s;
            descer_r <= tick_s && desce_s;
            if (tick_s) begin
                cnt_r <= '0;
                if (desce_s) begin
                    sentido_r <= !sentido_r;
                    desceu_r  <= 1'b1;
                end else begin
                    desceu_r  <= 1'b0;
                end
            end else if (marcha_s && !pausa) begin
                cnt_r <= cnt_r + CW'(1);
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Hit datapath: bloqueio holds until the bullet leaves every enemy.
    always_ff @(posedge CLOCK_50 or posedge resetInimigo) begin
        if (resetInimigo) begin
            vivo_r      <= '1;
            n_vivos_r   <= NW'(N);
            id_acerto_r <= '0;
            acerto_r    <= 1'b0;
            bloqueio_r  <= 1'b0;
        end else if (iniciar) begin
            vivo_r      <= '1;
            n_vivos_r   <= NW'(N);
            acerto_r    <= 1'b0;
            bloqueio_r  <= 1'b0;
        end else begin
            acerto_r <= grant_s;
            if (grant_s) begin
                vivo_r[idx_s] <= 1'b0;
                n_vivos_r     <= n_vivos_r - NW'(1);
                id_acerto_r   <= idx_s;
                bloqueio_r    <= 1'b1;
            end else if (hit_req == '0) begin
                bloqueio_r    <= 1'b0;
            end else begin
                bloqueio_r    <= bloqueio_r;
            end
        end
    end

    assign passo     = passo_r;
    assign descer    = descer_r;
    assign sentido   = sentido_r;
    assign vivo      = vivo_r;
    assign n_vivos   = n_vivos_r;
    assign acerto    = acerto_r;
    assign id_acerto = id_acerto_r;
    assign onda_fim  = onda_fim_r;
    assign invadido  = invadido_r;

endmodule
